// File: rtl/halt_dump_unit.sv
// Halt detector and post-run data-memory dump engine for the five-stage MIPS core.
// Freezes fetch on the halt word, drains the pipeline, then streams memory out over valid/ready.
module halt_dump_unit #(
    parameter int          MEM_WORDS    = 512,
    parameter int          ADDR_W       = 9,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_instruction,
    input  logic              if_valid,
    output logic              halt_out,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_done,
    output logic [31:0]       cycle_count
);

    localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [2:0] {RUN, DRAIN, READ, WAIT, HOLD, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            rd_addr     <= '0;
            halt_out    <= 1'b0;
            dump_data   <= '0;
            dump_addr   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    // The halt-detect edge itself is still counted as a RUN cycle.
                    if (cycle_count != 32'hFFFF_FFFF)
                        cycle_count <= cycle_count + 32'd1;
                    if (if_valid && (if_instruction == HALT_WORD)) begin
                        state     <= DRAIN;
                        halt_out  <= 1'b1;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state   <= READ;
                        rd_addr <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    // Memory returns the word one cycle after the READ edge.
                    dump_data <= mem_rd_data;
                    dump_addr <= rd_addr;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (dump_ready) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

    assign mem_rd_en   = (state == READ);
    assign mem_rd_addr = (state == READ) ? rd_addr : '0;
    assign dump_valid  = (state == HOLD);
    assign dump_done   = (state == DONE);

endmodule

// File: tb/tb_halt_dump_unit.sv
// Scoreboard bench for halt_dump_unit: halt detect, drain timing, full dump, backpressure, reset mid-dump.
`timescale 1ns/1ps
module tb_halt_dump_unit;

    localparam int          MEM_WORDS = 8;
    localparam int          ADDR_W    = 9;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       if_instruction;
    logic              if_valid;
    logic              halt_out;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_done;
    logic [31:0]       cycle_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    halt_dump_unit #(
        .MEM_WORDS(MEM_WORDS),
        .ADDR_W(ADDR_W),
        .DRAIN_CYCLES(4),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_instruction(if_instruction),
        .if_valid(if_valid),
        .halt_out(halt_out),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data(dump_data),
        .dump_addr(dump_addr),
        .dump_done(dump_done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Main memory preloaded with word i = 0xA000_0000 + i, registered read.
    always @(posedge clk)
        if (mem_rd_en)
            mem_rd_data <= 32'hA000_0000 + {23'd0, mem_rd_addr};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_halt"},  {31'd0, halt_out},   32'd0);
        check_val({tag, "_rden"},  {31'd0, mem_rd_en},  32'd0);
        check_val({tag, "_rdadr"}, {23'd0, mem_rd_addr}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check_val({tag, "_data"},  dump_data,           32'd0);
        check_val({tag, "_daddr"}, {23'd0, dump_addr},  32'd0);
        check_val({tag, "_done"},  {31'd0, dump_done},  32'd0);
        check_val({tag, "_cyc"},   cycle_count,         32'd0);
    endtask

    // n_pre valid non-halt fetches, then the halt word; returns at the negedge after the halt edge.
    task automatic do_halt(input int n_pre);
        for (int i = 0; i < n_pre; i++) begin
            if_instruction = $urandom & 32'h7FFF_FFFF;
            if_valid       = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < MEM_WORDS; i++)
            sb.push_back('{addr: i, data: 32'hA000_0000 + i});
        if_instruction = HALT;
        if_valid       = 1'b1;
        @(negedge clk);
        if_instruction = $urandom;
        if_valid       = 1'($urandom);
    endtask

    // Consume beats from the current negedge; optionally stall on word 3, or stop when word 3 is held.
    task automatic run_dump(input bit do_bp, input bit stop3);
        int    guard = 0;
        int    last_beat = -10;
        int    beats = 0;
        bit    bp_done = 0;
        bit    stopped = 0;
        beat_t exp;
        dump_ready = 1'b1;
        while (!dump_done && !stopped && guard < 300) begin
            if (dump_valid) begin
                if (stop3 && dump_addr == 3) begin
                    stopped = 1;
                end else begin
                    if (do_bp && !bp_done && dump_addr == 3) begin
                        bp_done    = 1;
                        dump_ready = 1'b0;
                        for (int k = 0; k < 5; k++) begin
                            check_val("bp_valid", {31'd0, dump_valid}, 32'd1);
                            check_val("bp_data", dump_data, 32'hA000_0003);
                            check_val("bp_addr", {23'd0, dump_addr}, 32'd3);
                            check_val("bp_rden", {31'd0, mem_rd_en}, 32'd0);
                            @(negedge clk);
                            guard++;
                        end
                        dump_ready = 1'b1;
                    end
                    check_val("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        exp = sb.pop_front();
                        check_val("beat_addr", {23'd0, dump_addr}, exp.addr);
                        check_val("beat_data", dump_data, exp.data);
                    end
                    $display("beat addr=%0d data=%h", dump_addr, dump_data);
                    beats++;
                    last_beat = guard;
                end
            end
            if (!stopped) begin
                @(negedge clk);
                guard++;
            end
        end
        check_val("dump_timeout", {31'd0, guard < 300}, 32'd1);
        if (stop3) begin
            check_val("stop3_beats", beats, 32'd3);
        end else begin
            check_val("beats", beats, MEM_WORDS);
            check_val("done_latency", guard - last_beat, 32'd1);
            check_val("done_flag", {31'd0, dump_done}, 32'd1);
            check_val("done_valid", {31'd0, dump_valid}, 32'd0);
            check_val("done_rden", {31'd0, mem_rd_en}, 32'd0);
            check_val("done_halt", {31'd0, halt_out}, 32'd1);
            check_val("sb_empty", sb.size(), 32'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        if_instruction = $urandom;
        if_valid       = 1'($urandom);
        dump_ready     = 1'($urandom);
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Halt word without if_valid must be ignored while counting continues.
        if_instruction = HALT;
        if_valid       = 1'b0;
        rst            = 1'b0;
        repeat (20) @(negedge clk);
        check_val("ign_cyc", cycle_count, 32'd20);
        check_val("ign_halt", {31'd0, halt_out}, 32'd0);
        check_val("ign_rden", {31'd0, mem_rd_en}, 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check_val("rst2_cyc", cycle_count, 32'd0);
        rst        = 1'b0;
        dump_ready = 1'b1;

        // Halt on the 10th edge; now in cycle 1 after E0.
        do_halt(9);
        check_val("halt_out", {31'd0, halt_out}, 32'd1);
        check_val("halt_cyc", cycle_count, 32'd10);
        for (int c = 1; c <= 5; c++) begin
            check_val($sformatf("drain_rden_c%0d", c), {31'd0, mem_rd_en}, {31'd0, c == 5});
            check_val("drain_cyc", cycle_count, 32'd10);
            if (c < 5) @(negedge clk);
        end
        check_val("first_rdadr", {23'd0, mem_rd_addr}, 32'd0);
        @(negedge clk);
        check_val("c6_valid", {31'd0, dump_valid}, 32'd0);
        @(negedge clk);
        check_val("c7_valid", {31'd0, dump_valid}, 32'd1);

        run_dump(1'b1, 1'b0);
        check_val("post_cyc", cycle_count, 32'd10);

        // Reset mid-dump, then a new halt restarts from address 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        do_halt(2);
        check_val("r2_cyc", cycle_count, 32'd3);
        run_dump(1'b0, 1'b1);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        do_halt(3);
        check_val("r3_cyc", cycle_count, 32'd4);
        run_dump(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
